exe_stage_pipe: RTL

EXE_STAGE_PIPE -- requirements
Module: exe_stage_pipe

---
 rtl/exe_stage_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage_pipe.sv
// rtl/exe_stage_pipe.sv - execute stage: operand forwarding, shifter, ALU with NZCV, branch target
// and an optional shift-add multiplier that holds the stage busy for DATA_W cycles.
module exe_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 24,
   parameter bit MUL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [3:0]        exe_cmd,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              wb_en,
   input  logic              s_bit,
   input  logic              imm,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [DATA_W-1:0] pc,
   input  logic [11:0]       shift_operand,
   input  logic [IMM_W-1:0]  signed_imm,
   input  logic [3:0]        dest,
   input  logic [1:0]        fwd_sel1,
   input  logic [1:0]        fwd_sel2,
   input  logic [DATA_W-1:0] fwd_mem_val,
   input  logic [DATA_W-1:0] fwd_wb_val,
   output logic              out_valid,
   output logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] val_rm_out,
   output logic [DATA_W-1:0] branch_addr,
   output logic [3:0]        dest_out,
   output logic              mem_r_en_out,
   output logic              mem_w_en_out,
   output logic              wb_en_out,
   output logic [3:0]        status,
   output logic              busy
);
   localparam int CNT_W = $clog2(DATA_W);
   localparam int MSB   = DATA_W - 1;
   localparam logic [3:0] CMD_MOV = 4'b0001, CMD_MVN = 4'b1001, CMD_ADD = 4'b0010,
                          CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                          CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000,
                          CMD_MUL = 4'b1010;

   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_nx;

   logic              accept, is_mul, start_mul, mul_last, cin;
   logic [DATA_W-1:0] a_op, rm_op, val2, alu_out, br_addr;
   logic [DATA_W:0]   sum;
   logic              c_nx, v_nx;
   logic [3:0]        alu_flags;
   logic [DATA_W-1:0] mcand, mplier, acc, acc_nx, h_rm, h_br;
   logic [CNT_W-1:0]  cnt;
   logic [3:0]        h_dest;
   logic              h_mr, h_mw, h_wb, h_s;

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel, input logic [DATA_W-1:0] r);
      case (sel)
         2'd1:    return fwd_mem_val;
         2'd2:    return fwd_wb_val;
         default: return r;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [5:0] n);
      int k;
      k = int'(n) % DATA_W;
      return DATA_W'({x, x} >> k);
   endfunction

   assign busy      = (state == MUL);
   assign in_ready  = ~busy;
   assign accept    = in_valid & in_ready & ~flush;
   assign is_mul    = (exe_cmd == CMD_MUL);
   assign start_mul = accept & is_mul & MUL_EN;
   assign mul_last  = busy && (cnt == CNT_W'(DATA_W - 1));
   assign a_op      = fwd_mux(fwd_sel1, val1);
   assign rm_op     = fwd_mux(fwd_sel2, val_rm);
   assign br_addr   = pc + DATA_W'({{DATA_W{signed_imm[IMM_W-1]}}, signed_imm, 2'b00});
   assign acc_nx    = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      val2 = '0;
      if (imm)
         val2 = ror(DATA_W'(shift_operand[7:0]), {1'b0, shift_operand[11:8], 1'b0});
      else if (mem_r_en || mem_w_en)
         val2 = DATA_W'(shift_operand);
      else begin
         case (shift_operand[6:5])
            2'b00:   val2 = rm_op << shift_operand[11:7];
            2'b01:   val2 = rm_op >> shift_operand[11:7];
            2'b10:   val2 = DATA_W'($signed(rm_op) >>> shift_operand[11:7]);
            default: val2 = ror(rm_op, {1'b0, shift_operand[11:7]});
         endcase
      end
   end

   // Subtraction is A + ~B + cin, so the carry out is already NOT borrow.
   always_comb begin
      sum     = '0;
      cin     = 1'b0;
      alu_out = '0;
      c_nx    = status[1];
      v_nx    = status[0];
      case (exe_cmd)
         CMD_MOV: alu_out = val2;
         CMD_MVN: alu_out = ~val2;
         CMD_ADD, CMD_ADC: begin
            cin     = (exe_cmd == CMD_ADC) ? status[1] : 1'b0;
            sum     = {1'b0, a_op} + {1'b0, val2} + {{DATA_W{1'b0}}, cin};
            alu_out = sum[DATA_W-1:0];
            c_nx    = sum[DATA_W];
            v_nx    = (a_op[MSB] == val2[MSB]) && (alu_out[MSB] != a_op[MSB]);
         end
         CMD_SUB, CMD_SBC: begin
            cin     = (exe_cmd == CMD_SBC) ? status[1] : 1'b1;
            sum     = {1'b0, a_op} + {1'b0, ~val2} + {{DATA_W{1'b0}}, cin};
            alu_out = sum[DATA_W-1:0];
            c_nx    = sum[DATA_W];
            v_nx    = (a_op[MSB] != val2[MSB]) && (alu_out[MSB] != a_op[MSB]);
         end
         CMD_AND: alu_out = a_op & val2;
         CMD_ORR: alu_out = a_op | val2;
         CMD_EOR: alu_out = a_op ^ val2;
         default: alu_out = '0;
      endcase
      alu_flags = {alu_out[MSB], alu_out == '0, c_nx, v_nx};
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start_mul) state_nx = MUL;
         MUL:     if (flush || mul_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         out_valid    <= 1'b0;
         alu_res      <= '0;
         val_rm_out   <= '0;
         branch_addr  <= '0;
         dest_out     <= '0;
         mem_r_en_out <= 1'b0;
         mem_w_en_out <= 1'b0;
         wb_en_out    <= 1'b0;
         status       <= '0;
         mcand        <= '0;
         mplier       <= '0;
         acc          <= '0;
         cnt          <= '0;
         h_rm         <= '0;
         h_br         <= '0;
         h_dest       <= '0;
         h_mr         <= 1'b0;
         h_mw         <= 1'b0;
         h_wb         <= 1'b0;
         h_s          <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         mem_r_en_out <= 1'b0;
         mem_w_en_out <= 1'b0;
         wb_en_out    <= 1'b0;
         if (start_mul) begin
            mcand  <= a_op;
            mplier <= rm_op;
            acc    <= '0;
            cnt    <= '0;
            h_rm   <= rm_op;
            h_br   <= br_addr;
            h_dest <= dest;
            h_mr   <= mem_r_en;
            h_mw   <= mem_w_en;
            h_wb   <= wb_en;
            h_s    <= s_bit;
         end else if (accept) begin
            // With MUL_EN=0 a MUL arrives here and retires as a NOP.
            out_valid    <= 1'b1;
            alu_res      <= alu_out;
            val_rm_out   <= rm_op;
            branch_addr  <= br_addr;
            dest_out     <= dest;
            mem_r_en_out <= mem_r_en & ~is_mul;
            mem_w_en_out <= mem_w_en & ~is_mul;
            wb_en_out    <= wb_en & ~is_mul;
            if (s_bit && !is_mul) status <= alu_flags;
         end else if (busy && !flush) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (mul_last) begin
               out_valid    <= 1'b1;
               alu_res      <= acc_nx;
               val_rm_out   <= h_rm;
               branch_addr  <= h_br;
               dest_out     <= h_dest;
               mem_r_en_out <= h_mr;
               mem_w_en_out <= h_mw;
               wb_en_out    <= h_wb;
               if (h_s) status[3:2] <= {acc_nx[MSB], acc_nx == '0};
            end
         end
      end
   end
endmodule
